// File: rtl/sum_channel_scaler.sv
// N-channel affine conditioner: out[k] = sat((sum + offset[k]) * gain[k]), 3-stage pipeline.
// Define SUM_SCALER_SAT_FLAG_EN to add sticky per-channel saturation flags (sat_flags/sat_clear).
module sum_channel_scaler #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned IN_W      = 16,
    parameter int unsigned IN_FRAC   = 15,
    parameter int unsigned GAIN_W    = 10,
    parameter int unsigned GAIN_FRAC = 7,
    parameter int unsigned OUT_W     = 24,
    parameter int unsigned OUT_FRAC  = 20,
    parameter int unsigned ADDR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int unsigned CFG_W     = (IN_W > GAIN_W) ? IN_W : GAIN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_sample,
    output logic                     out_valid,
    output logic [NUM_CH*OUT_W-1:0]  out_data,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [CFG_W-1:0]         cfg_wdata,
    input  logic                     cfg_commit,
    output logic                     cfg_pending
`ifdef SUM_SCALER_SAT_FLAG_EN
    ,
    output logic [NUM_CH-1:0]        sat_flags,
    input  logic                     sat_clear
`endif
);

    localparam int unsigned A_W    = IN_W + 1;
    localparam int unsigned P_W    = A_W + GAIN_W;
    localparam int unsigned P_FRAC = IN_FRAC + GAIN_FRAC;
    localparam int unsigned DROP   = (P_FRAC > OUT_FRAC) ? P_FRAC - OUT_FRAC : 0;
    localparam int unsigned LSH    = (OUT_FRAC > P_FRAC) ? OUT_FRAC - P_FRAC : 0;
    // One guard bit so the rounding add cannot wrap.
    localparam int unsigned AL_W   = P_W + 1 + LSH;
    localparam int unsigned RND_SH = (DROP > 0) ? DROP - 1 : 0;

    localparam logic signed [AL_W-1:0]   RND      = (DROP > 0) ? (AL_W'(1) <<< RND_SH) : '0;
    localparam logic signed [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) <<< GAIN_FRAC;
    localparam logic [OUT_W-1:0]         OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]         OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    // Coefficient banks
    logic signed [IN_W-1:0]   off_sh_q   [NUM_CH];
    logic signed [IN_W-1:0]   off_sh_d   [NUM_CH];
    logic signed [IN_W-1:0]   off_act_q  [NUM_CH];
    logic signed [GAIN_W-1:0] gain_sh_q  [NUM_CH];
    logic signed [GAIN_W-1:0] gain_sh_d  [NUM_CH];
    logic signed [GAIN_W-1:0] gain_act_q [NUM_CH];
    logic                     addr_ok;
    logic                     wr_ok;

    always_comb begin
        addr_ok = ({1'b0, cfg_addr} < (ADDR_W+1)'(NUM_CH));
        wr_ok   = cfg_we && addr_ok;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            off_sh_d[k]  = off_sh_q[k];
            gain_sh_d[k] = gain_sh_q[k];
            if (wr_ok && (cfg_addr == ADDR_W'(k))) begin
                if (cfg_sel) begin
                    gain_sh_d[k] = cfg_wdata[GAIN_W-1:0];
                end else begin
                    off_sh_d[k] = cfg_wdata[IN_W-1:0];
                end
            end
        end
    end

    // Commit copies the post-write shadow, so a same-cycle write is included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                off_sh_q[k]   <= '0;
                off_act_q[k]  <= '0;
                gain_sh_q[k]  <= GAIN_ONE;
                gain_act_q[k] <= GAIN_ONE;
            end
            cfg_pending <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                off_sh_q[k]  <= off_sh_d[k];
                gain_sh_q[k] <= gain_sh_d[k];
                if (cfg_commit) begin
                    off_act_q[k]  <= off_sh_d[k];
                    gain_act_q[k] <= gain_sh_d[k];
                end
            end
            if (cfg_commit) begin
                cfg_pending <= 1'b0;
            end else if (wr_ok) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    // Pipeline registers
    logic                     v1_q;
    logic                     v2_q;
    logic signed [A_W-1:0]    a_q  [NUM_CH];
    logic signed [GAIN_W-1:0] g1_q [NUM_CH];
    logic signed [P_W-1:0]    p_q  [NUM_CH];
    logic [OUT_W-1:0]         sat_val [NUM_CH];
`ifdef SUM_SCALER_SAT_FLAG_EN
    logic                     sat_hit [NUM_CH];
`endif

    // S1 snapshots offset and gain together so the sample sees one coherent set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                a_q[k]  <= '0;
                g1_q[k] <= '0;
                p_q[k]  <= '0;
            end
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (in_valid) begin
                    a_q[k]  <= A_W'(in_sample) + A_W'(off_act_q[k]);
                    g1_q[k] <= gain_act_q[k];
                end
                if (v1_q) begin
                    p_q[k] <= P_W'(a_q[k]) * P_W'(g1_q[k]);
                end
            end
        end
    end

    // S3 alignment: round half toward +inf, then saturate.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [AL_W-1:0] ext;
        logic signed [AL_W-1:0] aligned;

        always_comb begin
            ext     = AL_W'(p_q[k]) + RND;
            aligned = (ext >>> DROP) <<< LSH;
        end

        if (AL_W > OUT_W) begin : g_sat
            logic [AL_W-OUT_W:0] hi;
            logic                ovf;
            assign hi  = aligned[AL_W-1:OUT_W-1];
            assign ovf = !((&hi) || !(|hi));
            assign sat_val[k] = !ovf           ? aligned[OUT_W-1:0] :
                                aligned[AL_W-1] ? OUT_MIN : OUT_MAX;
`ifdef SUM_SCALER_SAT_FLAG_EN
            assign sat_hit[k] = ovf;
`endif
        end else begin : g_nosat
            assign sat_val[k] = OUT_W'(aligned);
`ifdef SUM_SCALER_SAT_FLAG_EN
            assign sat_hit[k] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                for (int k = 0; k < int'(NUM_CH); k++) begin
                    out_data[k*OUT_W +: OUT_W] <= sat_val[k];
                end
            end
        end
    end

`ifdef SUM_SCALER_SAT_FLAG_EN
    logic [NUM_CH-1:0] sat_set;

    always_comb begin
        sat_set = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            sat_set[k] = v2_q && sat_hit[k];
        end
    end

    // A new saturation event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flags <= '0;
        end else begin
            sat_flags <= (sat_clear ? '0 : sat_flags) | sat_set;
        end
    end
`endif

endmodule

// File: tb/tb_sum_channel_scaler.sv
// Scoreboard bench for sum_channel_scaler: directed vectors, monitor checks data and latency.
module tb_sum_channel_scaler;

    localparam int NUM_CH = 4;
    localparam int OUT_W  = 24;
    localparam int DW     = NUM_CH * OUT_W;
    localparam logic [23:0] D = 24'h080000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_sample = '0;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               cfg_we = 1'b0;
    logic               cfg_sel = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [15:0]        cfg_wdata = '0;
    logic               cfg_commit = 1'b0;
    logic               cfg_pending;
`ifdef SUM_SCALER_SAT_FLAG_EN
    logic [3:0]         sat_flags;
    logic               sat_clear = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] last_exp = '0;

    sum_channel_scaler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_pending(cfg_pending)
`ifdef SUM_SCALER_SAT_FLAG_EN
        ,
        .sat_flags  (sat_flags),
        .sat_clear  (sat_clear)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pk(input logic [23:0] c0, input logic [23:0] c1,
                                         input logic [23:0] c2, input logic [23:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Monitor: pops on every out_valid, otherwise checks out_data holds.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) last_exp = '0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("latency", cyc, e.due);
                    last_exp = e.data;
                end
            end else begin
                chk("hold", out_data, last_exp);
            end
        end
    end

    task automatic step(input logic iv, input logic [15:0] s, input logic [DW-1:0] exp,
                        input logic we, input logic sel, input logic [1:0] addr,
                        input logic [15:0] wd, input logic cm);
        in_valid   = iv;
        in_sample  = s;
        cfg_we     = we;
        cfg_sel    = sel;
        cfg_addr   = addr;
        cfg_wdata  = wd;
        cfg_commit = cm;
        if (iv) sb.push_back('{data: exp, due: cyc + 3});
        @(negedge clk);
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic sample(input logic [15:0] s, input logic [DW-1:0] exp);
        step(1'b1, s, exp, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic cfg(input logic sel, input logic [1:0] addr, input logic [15:0] wd,
                       input logic cm);
        step(1'b0, 16'h0, '0, 1'b1, sel, addr, wd, cm);
    endtask

    task automatic commit();
        step(1'b0, 16'h0, '0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    logic [DW-1:0] old_set, new_set, r_p2;
    logic          bub [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pending", cfg_pending, 0);
        reset = 1'b1;
        @(negedge clk);

        // Defaults: unity gain, zero offset; 0.5 in Q15 -> 0.5 in Q20.
        sample(16'h4000, pk(D, D, D, D));
        drain();

        cfg(1'b0, 2'd1, 16'h2000, 1'b0);
        chk("pending_after_write", cfg_pending, 1);
        sample(16'h4000, pk(D, D, D, D));
        cfg(1'b1, 2'd1, 16'h0100, 1'b0);
        commit();
        chk("pending_after_commit", cfg_pending, 0);
        sample(16'h4000, pk(D, 24'h180000, D, D));
        drain();

        commit();
        sample(16'h4000, pk(D, 24'h180000, D, D));
        drain();

        // Mid-stream commit: samples up to the commit cycle use the old set.
        old_set = pk(D, 24'h180000, D, D);
        new_set = pk(24'h040000, 24'h0C0000, D, D);
        step(1'b1, 16'h4000, old_set, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b1, 16'h4000, old_set, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b1, 16'h4000, old_set, 1'b1, 1'b1, 2'd0, 16'h0040, 1'b0);
        chk("pending_stream_write", cfg_pending, 1);
        step(1'b1, 16'h4000, old_set, 1'b1, 1'b1, 2'd1, 16'h0080, 1'b1);
        chk("pending_stream_commit", cfg_pending, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h4000, new_set, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        drain();

        // Near full scale: (1.99994 * 3.992) = 7.984 and 1.99994 * -4.0 both stay in range.
        cfg(1'b1, 2'd2, 16'h01FF, 1'b0);
        cfg(1'b0, 2'd2, 16'h7FFF, 1'b1);
        sample(16'h7FFF, pk(24'h07FFF0, 24'h13FFE0, 24'h7FBF01, 24'h0FFFE0));
        drain();
        cfg(1'b1, 2'd2, 16'h0200, 1'b1);
        sample(16'h7FFF, pk(24'h07FFF0, 24'h13FFE0, 24'h800100, 24'h0FFFE0));
        drain();
`ifdef SUM_SCALER_SAT_FLAG_EN
        chk("sat_flags_none", sat_flags, 0);
`endif
        // -2.0 * -4.0 = +8.0 exceeds the Q3.20 range -> clamp to max.
        cfg(1'b0, 2'd2, 16'h8000, 1'b1);
        sample(16'h8000, pk(24'hF80000, 24'hF40000, 24'h7FFFFF, 24'hF00000));
        drain();
`ifdef SUM_SCALER_SAT_FLAG_EN
        chk("sat_flags_set", sat_flags, 4'b0100);
        repeat (3) @(negedge clk);
        chk("sat_flags_sticky", sat_flags, 4'b0100);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        chk("sat_flags_clear", sat_flags, 0);
`endif

        // Rounding ties: ch3 gain 129 gives +/-258 in Q22 -> 65 and -64.
        cfg(1'b1, 2'd3, 16'h0081, 1'b1);
        r_p2 = pk(24'h000020, 24'h040040, 24'h3FFF00, 24'h000041);
        sample(16'h0002, r_p2);
        sample(16'hFFFE, pk(24'hFFFFE0, 24'h03FFC0, 24'h400100, 24'hFFFFC0));
        drain();

        for (int i = 0; i < 5; i++) step(bub[i], 16'h0002, r_p2, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        drain();

        // Reset with two samples in flight and a pending shadow write.
        cfg(1'b0, 2'd0, 16'h1234, 1'b0);
        chk("pending_before_reset", cfg_pending, 1);
        in_valid = 1'b1;
        in_sample = 16'h4000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_valid_after_reset", out_valid, 0);
        end
        chk("pending_after_reset", cfg_pending, 0);
        commit();
        sample(16'h4000, pk(D, D, D, D));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
